spi_slave_rtl: RTL and testbench
================================

# spi_slave_rtl

Synthesizable SPI responder that terminates the bus driven by our SPI master bench model and presents received bytes on a simple byte-stream interface to on-chip logic. SPI pins are asynchronous to the system clock; the block oversamples `sck` and `cs_n`, so no logic runs in the `sck` domain. Each byte clocked in on `mosi` is delivered on `rx_data`. Each byte shifted out on `miso` is taken from a single-entry transmit holding register, with `0x00` sent when that register is empty.

## Interface
- `PHASE`, default 0: CPHA. 0 means sample on the leading edge and shift on the trailing edge. 1 means shift on the leading edge and sample on the trailing edge.
- `ACTIVE`, default 0: CPOL, the idle level of `sck`.
- `clock`  in  1  system clock. One clock only.
- `rst_n`  in  1  reset, synchronous and active-low.
- `cs_n`  in  1  SPI chip select, active low, asynchronous.
- `sck`  in  1  SPI clock, asynchronous.
- `mosi`  in  1  SPI data from the master.
- `miso`  out  1  SPI data to the master. Driven 0 while deselected.
- `rx_data`  out  8  last complete received byte, MSB first on the wire.
- `rx_valid`  out  1  one-cycle pulse; `rx_data` is new.
- `tx_data`  in  8  next byte to transmit.
- `tx_valid`  in  1  `tx_data` offered.
- `tx_ready`  out  1  holding register empty. A transfer occurs when `tx_valid && tx_ready`.
- `busy`  out  1  frame in progress (FSM not IDLE).
- `byte_cnt`  out  16  bytes completed in the current frame.
- `tx_underrun`  out  1  one-cycle pulse; `0x00` was substituted for an empty holding register.

## Operation
- **Input synchronization**
  - `sck`, `cs_n` and `mosi` each pass through 2-FF synchronizers.
  - Edge detection on the synchronized `sck`: a leading edge is an idle→active transition, a trailing edge is active→idle.
- **Edge roles**
  - Sample edge: leading if `PHASE`=0, trailing if `PHASE`=1.
  - Shift edge: the other edge.
- **FSM**
  - IDLE→ACTIVE on a synchronized `cs_n` falling edge. On this transition: `bit_cnt`=0, `byte_cnt`=0, `busy`=1.
  - ACTIVE→IDLE on a synchronized `cs_n` rising edge, regardless of `bit_cnt`. Any partial byte is discarded and `rx_valid` is not pulsed.
- **Sample edge**
  - `rx_sr` <= {`rx_sr`[6:0], `mosi_s`}.
  - `bit_cnt` increments modulo 8 (3 bits).
  - When `bit_cnt` was 7: `rx_data` <= the completed byte, `rx_valid` pulses, and `byte_cnt` increments. `byte_cnt` saturates at 0xFFFF.
- **Fetch**
  - If the holding register is full, `tx_sr` <= holding and the holding register is cleared.
  - Otherwise `tx_sr` <= 0x00 and `tx_underrun` pulses.
- **When fetches occur**
  - `PHASE`=0: fetch on entry to ACTIVE, and on every shift edge with `bit_cnt`==0. Every other shift edge does `tx_sr` <<= 1.
  - `PHASE`=1: fetch on every shift edge with `bit_cnt`==0. Every other shift edge does `tx_sr` <<= 1.
- **`miso`**
  - `miso` = `tx_sr`[7] (registered) while ACTIVE, 0 in IDLE.
- **Holding register**
  - `tx_ready` = !full.
  - If a write and a fetch fall in the same cycle with the register empty, the fetch sees empty (underrun) and the write lands in the register. There is no bypass path.
  - Holding contents persist across frames.

## Timing
- **Oversampling:** `clock` must be at least 8× the `sck` frequency. Each `sck` high and low phase must be at least 4 `clock` cycles. Behaviour outside this limit is undefined.
- **Latency:** `rx_valid` is asserted exactly 3 `clock` cycles after the pin-level 8th sample edge (2 sync stages plus 1 edge register), with the output registered in that third cycle.
- **`miso` update:** `miso` updates 3 cycles after a pin-level shift edge. For `PHASE`=0, the first MSB appears 3 cycles after the `cs_n` fall.
- **Reset values:**
  - Outputs: `miso`=0, `rx_data`=0, `rx_valid`=0, `tx_ready`=1, `busy`=0, `byte_cnt`=0, `tx_underrun`=0.
  - Internal state: holding register empty, FSM IDLE.
- **Reset during a frame with `cs_n` held low:** the `cs_n` synchronizer resets to 0, so no falling edge is seen and the block stays IDLE. A new frame starts only after `cs_n` goes high and then low again.
- **Back-to-back frames:** `cs_n` high for at least 4 cycles between frames.

## Structure
- Package `spi_pkg`:
  - `typedef enum logic {IDLE, ACTIVE} spi_slv_state_t`
  - `localparam SPI_FILL_BYTE = 8'h00`
  - `localparam SPI_BYTE_W = 8`
- Sub-module `spi_sync_edge`: 2-FF synchronizer plus rise/fall pulse outputs, with a reset-value parameter.
  - Instantiated for `sck` with reset value `ACTIVE`.
  - Instantiated for `cs_n` with reset value 0.
  - `mosi` uses a plain 2-FF synchronizer.

## Test plan
- **Reset:** hold `rst_n` low 2 cycles with random pins. All outputs must equal their reset values and `tx_ready`=1.
- **Mode 0 single byte:** write 0xA5 to the holding register, master sends 0x3C. Expect `rx_data`=0x3C with one `rx_valid` pulse, master reads 0xA5, `byte_cnt`=1, `tx_underrun` never pulses.
- **Burst:** master writes 00 01 02 03 04 01 02 03 04, and the bench refills 0x10+i whenever `tx_ready` is high. Expect 9 `rx_valid` pulses carrying the same sequence, `byte_cnt`=9, master reads 0x10..0x18.
- **Underrun:** nothing loaded, 2-byte frame. Expect master reads 0x00 0x00 and `tx_underrun` pulses twice.
- **Abort:** `cs_n` rises after 5 bits. Expect no `rx_valid` and `busy`=0. The next frame sending 0xF0 returns `rx_data`=0xF0, i.e. stays byte-aligned.
- **Reset mid-frame and `PHASE`=1/`ACTIVE`=1 instance:**
  - Pulse `rst_n` mid-byte with `cs_n` low. Expect `busy` stays 0 until `cs_n` toggles high then low.
  - On the `PHASE`=1/`ACTIVE`=1 instance, exchange 0x81↔0x7E correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the oversampled SPI responder.
package spi_pkg;

  typedef enum logic {IDLE, ACTIVE} spi_slv_state_t;

  localparam int SPI_BYTE_W = 8;
  localparam int SPI_BIT_CNT_W = $clog2(SPI_BYTE_W);
  localparam logic [SPI_BYTE_W-1:0] SPI_FILL_BYTE = 8'h00;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, with one extra register
// so rise/fall pulses are produced in the system clock domain.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);
  import spi_pkg::*;

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      s3 <= RST_VAL;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/spi_slave_rtl.sv
// SPI responder running entirely in the system clock domain: sck/cs_n are
// oversampled, received bytes stream out on rx_*, transmit bytes come from a
// single-entry holding register.
module spi_slave_rtl #(
  parameter logic PHASE  = 1'b0,
  parameter logic ACTIVE = 1'b0
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        cs_n,
  input  logic        sck,
  input  logic        mosi,
  output logic        miso,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        busy,
  output logic [15:0] byte_cnt,
  output logic        tx_underrun
);
  import spi_pkg::*;

  // state  | meaning
  // IDLE   | deselected, miso held low, sck edges ignored
  // ACTIVE | frame in progress, bits sampled/shifted on sck edges

  localparam logic ST_IDLE   = spi_pkg::IDLE;
  localparam logic ST_ACTIVE = spi_pkg::ACTIVE;
  localparam logic [SPI_BIT_CNT_W-1:0] LAST_BIT = SPI_BIT_CNT_W'(SPI_BYTE_W - 1);

  logic sck_rise;
  logic sck_fall;
  logic cs_rise;
  logic cs_fall;
  logic mosi_m;
  logic mosi_s;

  logic                      state;
  logic [SPI_BIT_CNT_W-1:0]  bit_cnt;
  logic [SPI_BYTE_W-1:0]     rx_sr;
  logic [SPI_BYTE_W-1:0]     rx_next;
  logic [SPI_BYTE_W-1:0]     tx_sr;
  logic [SPI_BYTE_W-1:0]     hold_data;
  logic                      hold_full;

  logic leading_edge;
  logic trailing_edge;
  logic sample_edge;
  logic shift_edge;
  logic enter;
  logic leave;
  logic do_sample;
  logic do_shift;
  logic fetch;
  logic hold_wr;

  spi_sync_edge #(.RST_VAL(ACTIVE)) u_sck_sync (
    .clock (clock),
    .rst_n (rst_n),
    .d     (sck),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  // Resetting to 0 means a cs_n already low at reset release is not a new frame.
  spi_sync_edge #(.RST_VAL(1'b0)) u_cs_sync (
    .clock (clock),
    .rst_n (rst_n),
    .d     (cs_n),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      mosi_m <= 1'b0;
      mosi_s <= 1'b0;
    end else begin
      mosi_m <= mosi;
      mosi_s <= mosi_m;
    end
  end

  assign leading_edge  = ACTIVE ? sck_fall : sck_rise;
  assign trailing_edge = ACTIVE ? sck_rise : sck_fall;
  assign sample_edge   = PHASE ? trailing_edge : leading_edge;
  assign shift_edge    = PHASE ? leading_edge  : trailing_edge;

  assign busy      = (state == ST_ACTIVE);
  assign enter     = !busy && cs_fall;
  assign leave     = busy && cs_rise;
  assign do_sample = busy && !cs_rise && sample_edge;
  assign do_shift  = busy && !cs_rise && shift_edge;
  assign rx_next   = {rx_sr[SPI_BYTE_W-2:0], mosi_s};

  // CPHA=0 must present the MSB before the first sck edge, hence the entry fetch.
  assign fetch   = (enter && !PHASE) || (do_shift && (bit_cnt == '0));
  assign hold_wr = tx_valid && !hold_full;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      byte_cnt <= 16'd0;
      rx_sr    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (enter) begin
        state    <= ST_ACTIVE;
        bit_cnt  <= '0;
        byte_cnt <= 16'd0;
      end else if (leave) begin
        state <= ST_IDLE;
      end else if (do_sample) begin
        rx_sr   <= rx_next;
        bit_cnt <= bit_cnt + SPI_BIT_CNT_W'(1);
        if (bit_cnt == LAST_BIT) begin
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
          byte_cnt <= sat_inc16(byte_cnt);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      tx_sr       <= '0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= fetch && !hold_full;
      if (fetch) begin
        tx_sr <= hold_full ? hold_data : SPI_FILL_BYTE;
      end else if (do_shift) begin
        tx_sr <= {tx_sr[SPI_BYTE_W-2:0], 1'b0};
      end
    end
  end

  // A write coinciding with an empty-register fetch lands after the fetch; no bypass.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (fetch && hold_full) begin
      hold_full <= 1'b0;
    end else if (hold_wr) begin
      hold_full <= 1'b1;
      hold_data <= tx_data;
    end
  end

  assign tx_ready = !hold_full;
  assign miso     = busy ? tx_sr[SPI_BYTE_W-1] : 1'b0;

endmodule

// File: tb/tb_spi_slave_rtl.sv
// Bench for spi_slave_rtl: mode 0 and mode 3 instances behind one master model.
module tb_spi_slave_rtl;

  localparam int HALF = 6;
  localparam int GAP  = 8;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  logic m_cs_n = 1'b1;
  logic m_sck = 1'b0;
  logic m_mosi = 1'b0;
  logic [7:0] m_tx_data = 8'h00;
  logic m_tx_valid = 1'b0;
  logic m_miso;
  logic m_ready;

  logic cs_n0, sck0, tx_valid0, miso0, rx_valid0, tx_ready0, busy0, und0;
  logic cs_n1, sck1, tx_valid1, miso1, rx_valid1, tx_ready1, busy1, und1;
  logic [7:0] rx_data0, rx_data1;
  logic [15:0] byte_cnt0, byte_cnt1;

  int n_vec = 0;
  int n_bad = 0;
  int n_rxv0 = 0, n_und0 = 0, n_rxv1 = 0, n_und1 = 0;

  logic [7:0] exp_rx0[$];
  logic [7:0] exp_rx1[$];
  logic [7:0] exp_mi[$];
  logic [7:0] f_mo[16];
  logic [7:0] f_mi[16];

  typedef struct {
    logic [7:0] mo;
    logic       load;
    logic [7:0] tx;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
    int         exp_und;
  } vec_t;
  vec_t tbl[5];

  always #5 clock = ~clock;

  assign cs_n0     = sel ? 1'b1 : m_cs_n;
  assign sck0      = sel ? 1'b0 : m_sck;
  assign tx_valid0 = m_tx_valid & ~sel;
  assign cs_n1     = sel ? m_cs_n : 1'b1;
  assign sck1      = sel ? m_sck : 1'b1;
  assign tx_valid1 = m_tx_valid & sel;
  assign m_miso    = sel ? miso1 : miso0;
  assign m_ready   = sel ? tx_ready1 : tx_ready0;

  spi_slave_rtl #(.PHASE(1'b0), .ACTIVE(1'b0)) dut0 (
    .clock(clock), .rst_n(rst_n), .cs_n(cs_n0), .sck(sck0), .mosi(m_mosi),
    .miso(miso0), .rx_data(rx_data0), .rx_valid(rx_valid0), .tx_data(m_tx_data),
    .tx_valid(tx_valid0), .tx_ready(tx_ready0), .busy(busy0), .byte_cnt(byte_cnt0),
    .tx_underrun(und0)
  );

  spi_slave_rtl #(.PHASE(1'b1), .ACTIVE(1'b1)) dut1 (
    .clock(clock), .rst_n(rst_n), .cs_n(cs_n1), .sck(sck1), .mosi(m_mosi),
    .miso(miso1), .rx_data(rx_data1), .rx_valid(rx_valid1), .tx_data(m_tx_data),
    .tx_valid(tx_valid1), .tx_ready(tx_ready1), .busy(busy1), .byte_cnt(byte_cnt1),
    .tx_underrun(und1)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard side: received bytes are popped as the DUTs produce them.
  always @(negedge clock) begin
    if (rx_valid0) begin
      n_rxv0++;
      if (exp_rx0.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL rx0_unexpected: got %02h, none expected", rx_data0);
      end else chk("rx0_data", 32'(rx_data0), 32'(exp_rx0.pop_front()));
    end
    if (rx_valid1) begin
      n_rxv1++;
      if (exp_rx1.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL rx1_unexpected: got %02h, none expected", rx_data1);
      end else chk("rx1_data", 32'(rx_data1), 32'(exp_rx1.pop_front()));
    end
    if (und0) n_und0++;
    if (und1) n_und1++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic load_tx(input logic [7:0] d);
    int budget = 2000;
    @(negedge clock);
    while (!m_ready && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    if (budget == 0) begin
      n_vec++; n_bad++;
      $display("FAIL tx_ready_timeout: got tx_ready=0 expected 1 for byte %02h", d);
    end
    m_tx_data  = d;
    m_tx_valid = 1'b1;
    @(negedge clock);
    m_tx_valid = 1'b0;
  endtask

  // Master model. CPHA=0 frames raise cs_n before the final trailing edge.
  task automatic frame(input int nbits);
    int idx, bi;
    logic cp;
    cp = sel;
    for (int i = 0; i < 16; i++) f_mi[i] = 8'h00;
    if (!sel) begin
      m_mosi = f_mo[0][7];
      m_cs_n = 1'b0;
      wait_cyc(HALF);
      for (int b = 0; b < nbits; b++) begin
        idx = b / 8; bi = 7 - (b % 8);
        f_mi[idx][bi] = m_miso;
        m_sck = ~cp;
        wait_cyc(HALF);
        if (b == nbits - 1) begin
          m_cs_n = 1'b1;
          wait_cyc(HALF);
          m_sck = cp;
        end else begin
          m_sck  = cp;
          m_mosi = f_mo[(b + 1) / 8][7 - ((b + 1) % 8)];
          wait_cyc(HALF);
        end
      end
    end else begin
      m_cs_n = 1'b0;
      wait_cyc(HALF);
      for (int b = 0; b < nbits; b++) begin
        idx = b / 8; bi = 7 - (b % 8);
        m_sck  = ~cp;
        m_mosi = f_mo[idx][bi];
        wait_cyc(HALF);
        f_mi[idx][bi] = m_miso;
        m_sck = cp;
        wait_cyc(HALF);
      end
      m_cs_n = 1'b1;
    end
    m_mosi = 1'b0;
    wait_cyc(GAP);
  endtask

  task automatic check_mi(input int nbytes);
    for (int k = 0; k < nbytes; k++) begin
      if (exp_mi.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL miso_unexpected: got %02h, none expected", f_mi[k]);
      end else chk("miso_byte", 32'(f_mi[k]), 32'(exp_mi.pop_front()));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rx0, u0, rx1, u1;
    logic busy_seen;
    logic [7:0] burst[9];

    tbl[0] = '{8'h3C, 1'b1, 8'hA5, 8'h3C, 8'hA5, 0};
    tbl[1] = '{8'hFF, 1'b1, 8'h00, 8'hFF, 8'h00, 0};
    tbl[2] = '{8'h00, 1'b1, 8'hFF, 8'h00, 8'hFF, 0};
    tbl[3] = '{8'h81, 1'b1, 8'h7E, 8'h81, 8'h7E, 0};
    tbl[4] = '{8'hC6, 1'b0, 8'h00, 8'hC6, 8'h00, 1};
    burst = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04};

    // reset with random pins
    rst_n = 1'b0;
    m_cs_n = 1'($urandom_range(0, 1));
    m_sck  = 1'($urandom_range(0, 1));
    m_mosi = 1'($urandom_range(0, 1));
    m_tx_valid = 1'($urandom_range(0, 1));
    m_tx_data  = 8'($urandom);
    wait_cyc(2);
    chk("rst_miso0", 32'(miso0), 0);
    chk("rst_rx_data0", 32'(rx_data0), 0);
    chk("rst_rx_valid0", 32'(rx_valid0), 0);
    chk("rst_tx_ready0", 32'(tx_ready0), 1);
    chk("rst_busy0", 32'(busy0), 0);
    chk("rst_byte_cnt0", 32'(byte_cnt0), 0);
    chk("rst_underrun0", 32'(und0), 0);
    chk("rst_miso1", 32'(miso1), 0);
    chk("rst_tx_ready1", 32'(tx_ready1), 1);
    chk("rst_busy1", 32'(busy1), 0);
    chk("rst_byte_cnt1", 32'(byte_cnt1), 0);
    m_cs_n = 1'b1; m_sck = 1'b0; m_mosi = 1'b0; m_tx_valid = 1'b0;
    rst_n = 1'b1;
    wait_cyc(8);
    chk("post_rst_tx_ready0", 32'(tx_ready0), 1);

    // table of single-byte mode 0 frames
    for (int i = 0; i < 5; i++) begin
      rx0 = n_rxv0; u0 = n_und0;
      if (tbl[i].load) load_tx(tbl[i].tx);
      exp_mi.push_back(tbl[i].exp_miso);
      exp_rx0.push_back(tbl[i].exp_rx);
      f_mo[0] = tbl[i].mo;
      frame(8);
      check_mi(1);
      chk("vec_rx_pulses", 32'(n_rxv0 - rx0), 1);
      chk("vec_underruns", 32'(n_und0 - u0), 32'(tbl[i].exp_und));
      chk("vec_byte_cnt", 32'(byte_cnt0), 1);
      chk("vec_busy_after", 32'(busy0), 0);
    end

    // burst with concurrent refill
    rx0 = n_rxv0; u0 = n_und0;
    for (int i = 0; i < 9; i++) begin
      f_mo[i] = burst[i];
      exp_rx0.push_back(burst[i]);
      exp_mi.push_back(8'h10 + 8'(i));
    end
    load_tx(8'h10);
    fork
      frame(72);
      begin
        for (int i = 1; i < 9; i++) load_tx(8'h10 + 8'(i));
      end
    join
    check_mi(9);
    chk("burst_rx_pulses", 32'(n_rxv0 - rx0), 9);
    chk("burst_byte_cnt", 32'(byte_cnt0), 9);
    chk("burst_underruns", 32'(n_und0 - u0), 0);

    // underrun: empty holding register over a 2-byte frame
    u0 = n_und0;
    f_mo[0] = 8'h55; f_mo[1] = 8'hAA;
    exp_rx0.push_back(8'h55); exp_rx0.push_back(8'hAA);
    exp_mi.push_back(8'h00); exp_mi.push_back(8'h00);
    frame(16);
    check_mi(2);
    chk("underrun_pulses", 32'(n_und0 - u0), 2);
    chk("underrun_byte_cnt", 32'(byte_cnt0), 2);

    // abort after 5 bits, then confirm byte alignment
    rx0 = n_rxv0;
    f_mo[0] = 8'hAA;
    frame(5);
    chk("abort_rx_pulses", 32'(n_rxv0 - rx0), 0);
    chk("abort_busy", 32'(busy0), 0);
    f_mo[0] = 8'hF0;
    exp_rx0.push_back(8'hF0);
    exp_mi.push_back(8'h00);
    frame(8);
    check_mi(1);
    chk("after_abort_rx_pulses", 32'(n_rxv0 - rx0), 1);
    chk("after_abort_byte_cnt", 32'(byte_cnt0), 1);

    // reset mid-frame with cs_n held low
    rx0 = n_rxv0;
    f_mo[0] = 8'h99;
    fork
      frame(8);
      begin
        wait_cyc(30);
        chk("midframe_busy", 32'(busy0), 1);
        wait_cyc(10);
        rst_n = 1'b0;
        wait_cyc(2);
        rst_n = 1'b1;
        busy_seen = 1'b0;
        repeat (20) begin
          @(negedge clock);
          if (busy0) busy_seen = 1'b1;
        end
        chk("rst_mid_busy", 32'(busy_seen), 0);
      end
    join
    chk("rst_mid_rx_pulses", 32'(n_rxv0 - rx0), 0);
    load_tx(8'hC3);
    exp_mi.push_back(8'hC3);
    exp_rx0.push_back(8'h5A);
    f_mo[0] = 8'h5A;
    frame(8);
    check_mi(1);
    chk("rst_recover_byte_cnt", 32'(byte_cnt0), 1);

    // mode 3 instance
    m_sck = 1'b1;
    m_cs_n = 1'b1;
    sel = 1'b1;
    wait_cyc(8);
    rx1 = n_rxv1; u1 = n_und1;
    load_tx(8'h7E);
    exp_mi.push_back(8'h7E);
    exp_rx1.push_back(8'h81);
    f_mo[0] = 8'h81;
    frame(8);
    check_mi(1);
    chk("m3_rx_pulses", 32'(n_rxv1 - rx1), 1);
    chk("m3_byte_cnt", 32'(byte_cnt1), 1);
    chk("m3_underruns", 32'(n_und1 - u1), 0);

    u1 = n_und1;
    f_mo[0] = 8'h12; f_mo[1] = 8'h34;
    exp_rx1.push_back(8'h12); exp_rx1.push_back(8'h34);
    exp_mi.push_back(8'h00); exp_mi.push_back(8'h00);
    frame(16);
    check_mi(2);
    chk("m3_underrun_pulses", 32'(n_und1 - u1), 2);
    chk("m3_byte_cnt2", 32'(byte_cnt1), 2);

    wait_cyc(10);
    chk("rx0_left", 32'(exp_rx0.size()), 0);
    chk("rx1_left", 32'(exp_rx1.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
